// File: rtl/cpu_debug_slave_pkg.sv
// Shared types and helpers for the CPU debug slave command path.
// Default widths match the original fixed 2-bit IR / 38-bit data capture.
package cpu_debug_slave_pkg;

  localparam int unsigned DefaultSrW = 38;
  localparam int unsigned DefaultIrW = 2;
  localparam int unsigned MaxIrW     = 8;
  localparam int unsigned MaxCh      = 2 ** MaxIrW;

  typedef struct packed {
    logic [DefaultIrW-1:0] ir;
    logic [DefaultSrW-1:0] payload;
  } cmd_t;

  // Callers truncate the result to their own channel count.
  function automatic logic [MaxCh-1:0] ch_onehot(input logic [MaxIrW-1:0] ir);
    ch_onehot     = '0;
    ch_onehot[ir] = 1'b1;
  endfunction

endpackage

// File: rtl/cpu_debug_slave_sync_edge.sv
// Synchroniser for a JTAG-domain level plus a registered rising-edge detector.
// A level already high when reset releases is never reported as an edge.
module cpu_debug_slave_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] vld_q, vld_d;
  logic                   low_q, low_d;
  logic                   rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    // vld tracks which chain stages hold real samples rather than reset zeros.
    vld_d  = {vld_q[SYNC_STAGES-2:0], 1'b1};
    low_d  = vld_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & low_q;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sync_q <= '0;
      vld_q  <= '0;
      low_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      vld_q  <= vld_d;
      low_q  <= low_d;
      rise_q <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/cpu_debug_slave_cmd_queue.sv
// System-clock command stage: captures JTAG update-DR commands into a FIFO and
// replays each as a one-cycle per-channel action pulse, throttled by act_ready.
module cpu_debug_slave_cmd_queue
  import cpu_debug_slave_pkg::*;
#(
  parameter int unsigned SR_W         = 38,
  parameter int unsigned IR_W         = 2,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter bit          FLUSH_ON_UIR = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [SR_W-1:0]          sr,
  input  logic [IR_W-1:0]          ir_in,
  input  logic                     vs_udr,
  input  logic                     vs_uir,
  input  logic                     act_ready,
  input  logic                     ovf_clr,
  output logic [SR_W-1:0]          jdo,
  output logic [2**IR_W-1:0]       take_action,
  output logic [2**IR_W-1:0]       take_no_action,
  output logic                     ir_update,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned NUM_CH = 2 ** IR_W;
  localparam int unsigned AW     = $clog2(DEPTH);

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] payload;
  } cmd_entry_t;

  cmd_entry_t        mem_q [DEPTH];
  cmd_entry_t        mem_d [DEPTH];
  logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [SR_W-1:0]   jdo_q, jdo_d;
  logic [NUM_CH-1:0] take_action_q, take_action_d;
  logic [NUM_CH-1:0] take_no_action_q, take_no_action_d;
  logic              ir_update_q, ir_update_d;
  logic              overflow_q, overflow_d;

  logic              udr_rise, uir_rise;
  logic              empty, full, flush, pop, push, drop;
  cmd_entry_t        head;
  logic [NUM_CH-1:0] head_sel;

  cpu_debug_slave_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_udr_sync (
    .clk_i   (clk),
    .reset_ni(reset_n),
    .async_i (vs_udr),
    .rise_o  (udr_rise)
  );

  cpu_debug_slave_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_uir_sync (
    .clk_i   (clk),
    .reset_ni(reset_n),
    .async_i (vs_uir),
    .rise_o  (uir_rise)
  );

  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    flush = FLUSH_ON_UIR && uir_rise;
    pop   = !empty && act_ready && !flush;
    // A pop frees the slot the push lands in, so a full queue can still accept.
    push  = udr_rise && (!full || pop) && !flush;
    drop  = udr_rise && full && !pop && !flush;

    head     = mem_q[rptr_q[AW-1:0]];
    head_sel = NUM_CH'(ch_onehot(MaxIrW'(head.ir)));

    mem_d = mem_q;
    if (push) begin
      mem_d[wptr_q[AW-1:0]] = '{ir: ir_in, payload: sr};
    end

    wptr_d = flush ? '0 : (push ? wptr_q + 1'b1 : wptr_q);
    rptr_d = flush ? '0 : (pop  ? rptr_q + 1'b1 : rptr_q);

    jdo_d            = pop ? head.payload : jdo_q;
    take_action_d    = (pop &&  head.payload[SR_W-1]) ? head_sel : '0;
    take_no_action_d = (pop && !head.payload[SR_W-1]) ? head_sel : '0;
    ir_update_d      = uir_rise;
    overflow_d       = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q           <= '0;
      rptr_q           <= '0;
      jdo_q            <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      ir_update_q      <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      wptr_q           <= wptr_d;
      rptr_q           <= rptr_d;
      jdo_q            <= jdo_d;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      ir_update_q      <= ir_update_d;
      overflow_q       <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign jdo            = jdo_q;
  assign take_action    = take_action_q;
  assign take_no_action = take_no_action_q;
  assign ir_update      = ir_update_q;
  assign overflow       = overflow_q;
  assign level          = wptr_q - rptr_q;

endmodule

// File: tb/tb_cpu_debug_slave_cmd_queue.sv
// Scoreboard bench for cpu_debug_slave_cmd_queue: two instances, flush off and on.
module tb_cpu_debug_slave_cmd_queue;

  localparam int unsigned SR_W   = 38;
  localparam int unsigned IR_W   = 2;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned LW     = 3;

  logic              clk, reset_n;
  logic [SR_W-1:0]   sr;
  logic [IR_W-1:0]   ir_in;
  logic              vs_udr, vs_uir, act_ready, ovf_clr;
  logic [SR_W-1:0]   jdo, jdo_f;
  logic [NUM_CH-1:0] take_action, take_no_action, take_action_f, take_no_action_f;
  logic              ir_update, ir_update_f, overflow, overflow_f;
  logic [LW-1:0]     level, level_f;

  typedef struct {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] payload;
  } exp_t;

  exp_t              expect_q[$];
  exp_t              mon_e;
  logic [NUM_CH-1:0] mon_ta, mon_tna;
  int                checks = 0;
  int                failures = 0;

  cpu_debug_slave_cmd_queue #(
    .SR_W(SR_W), .IR_W(IR_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .FLUSH_ON_UIR(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sr(sr), .ir_in(ir_in), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .act_ready(act_ready), .ovf_clr(ovf_clr), .jdo(jdo), .take_action(take_action),
    .take_no_action(take_no_action), .ir_update(ir_update), .overflow(overflow), .level(level)
  );

  cpu_debug_slave_cmd_queue #(
    .SR_W(SR_W), .IR_W(IR_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .FLUSH_ON_UIR(1'b1)
  ) dut_f (
    .clk(clk), .reset_n(reset_n), .sr(sr), .ir_in(ir_in), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .act_ready(act_ready), .ovf_clr(ovf_clr), .jdo(jdo_f), .take_action(take_action_f),
    .take_no_action(take_no_action_f), .ir_update(ir_update_f), .overflow(overflow_f),
    .level(level_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog elapsed=500000 required=finish_before_limit");
    $fatal(1, "timeout");
  end

  // Scoreboard consumer: every dispatch pulse must match the oldest expected command.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && (take_action | take_no_action) !== '0) begin
      checks++;
      if (expect_q.size() == 0) begin
        failures++;
        $display("FAIL dispatch_unexpected ta=%b tna=%b jdo=%h required=no_dispatch",
                 take_action, take_no_action, jdo);
      end else begin
        mon_e   = expect_q.pop_front();
        mon_ta  = mon_e.payload[SR_W-1] ? (NUM_CH'(1) << mon_e.ir) : '0;
        mon_tna = mon_e.payload[SR_W-1] ? '0 : (NUM_CH'(1) << mon_e.ir);
        if (take_action !== mon_ta || take_no_action !== mon_tna || jdo !== mon_e.payload) begin
          failures++;
          $display("FAIL dispatch_order ta=%b tna=%b jdo=%h required ta=%b tna=%b jdo=%h",
                   take_action, take_no_action, jdo, mon_ta, mon_tna, mon_e.payload);
        end
      end
    end
  end

  function automatic logic [SR_W-1:0] rnd_pl(input bit msb);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return {msb, r[SR_W-2:0]};
  endfunction

  task automatic push_cmd(input logic [IR_W-1:0] c_ir, input logic [SR_W-1:0] c_pl,
                          input bit expect_it, input bit hold_high);
    @(posedge clk); #1;
    sr = c_pl;
    ir_in = c_ir;
    vs_udr = 1'b1;
    if (expect_it) expect_q.push_back('{ir: c_ir, payload: c_pl});
    repeat (SYNC + 3) @(posedge clk);
    #1;
    if (!hold_high) begin
      vs_udr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (expect_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sr = '0; ir_in = '0; vs_udr = 1'b0; vs_uir = 1'b0;
    act_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    checks++;
    if ({jdo, take_action, take_no_action, ir_update, overflow, level} !== '0) begin
      failures++;
      $display("FAIL reset_state jdo=%h ta=%b tna=%b iru=%b ovf=%b lvl=%0d required all zero",
               jdo, take_action, take_no_action, ir_update, overflow, level);
    end
    repeat (SYNC + 2) @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [SR_W-1:0]   pl;
    logic [NUM_CH-1:0] want;
    bit                ok;
    pl = 38'h20_0000_00AB;
    act_ready = 1'b1;
    expect_q.push_back('{ir: 2'd2, payload: pl});
    sr = pl; ir_in = 2'd2; vs_udr = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      want = (k == SYNC + 2) ? 4'b0100 : 4'b0000;
      checks++;
      if (take_action !== want || take_no_action !== 4'b0000) begin
        failures++;
        $display("FAIL single_latency k=%0d ta=%b tna=%b required ta=%b tna=0000",
                 k, take_action, take_no_action, want);
      end
    end
    vs_udr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (jdo !== pl) begin
      failures++;
      $display("FAIL single_jdo got=%h required=%h", jdo, pl);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_drain pending=%0d required=0", expect_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [IR_W-1:0]   irs  [3] = '{2'd0, 2'd1, 2'd3};
    bit                msbs [3] = '{1'b0, 1'b1, 1'b0};
    logic [NUM_CH-1:0] ta_w [3] = '{4'b0000, 4'b0010, 4'b0000};
    logic [NUM_CH-1:0] tna_w[3] = '{4'b0001, 4'b0000, 4'b1000};
    act_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_cmd(irs[i], rnd_pl(msbs[i]), 1'b1, 1'b0);
      checks++;
      if (level !== LW'(i + 1)) begin
        failures++;
        $display("FAIL bp_level i=%0d got=%0d required=%0d", i, level, i + 1);
      end
    end
    act_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      checks++;
      if (take_action !== ta_w[j] || take_no_action !== tna_w[j]) begin
        failures++;
        $display("FAIL bp_sequence j=%0d ta=%b tna=%b required ta=%b tna=%b",
                 j, take_action, take_no_action, ta_w[j], tna_w[j]);
      end
    end
    checks++;
    if (level !== '0) begin failures++; $display("FAIL bp_empty got=%0d required=0", level); end
  endtask

  task automatic test_overflow();
    bit ok;
    act_ready = 1'b0;
    ovf_clr = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(IR_W'(i), rnd_pl(i[0]), (i < 4), 1'b0);
    checks++;
    if (level !== 3'd4 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_full lvl=%0d ovf=%b required lvl=4 ovf=1", level, overflow);
    end
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b required=0", overflow); end
    // Drop lands on the edge SYNC+1 after the first sampling edge; clear on exactly that edge.
    sr = rnd_pl(1'b1); ir_in = 2'd1; vs_udr = 1'b1;
    repeat (3) @(posedge clk);
    #1 ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b1 || level !== 3'd4) begin
      failures++;
      $display("FAIL ovf_set_wins ovf=%b lvl=%0d required ovf=1 lvl=4", overflow, level);
    end
    @(posedge clk); #1;
    vs_udr = 1'b0;
    repeat (2) @(posedge clk);
    #1 act_ready = 1'b1;
    wait_drain(ok);
    checks++;
    if (!ok || level !== '0) begin
      failures++;
      $display("FAIL ovf_drain pending=%0d lvl=%0d required 0 0", expect_q.size(), level);
    end
  endtask

  task automatic test_wrap();
    int lvl;
    bit ok;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    lvl = 0;
    for (int i = 0; i < 10; i++) begin
      act_ready = (i % 4 == 3);
      push_cmd(IR_W'($urandom_range(0, 3)), rnd_pl(1'($urandom_range(0, 1))), 1'b1, 1'b0);
      lvl = act_ready ? 0 : lvl + 1;
      checks++;
      if (level !== LW'(lvl) || lvl > DEPTH) begin
        failures++;
        $display("FAIL wrap_level i=%0d got=%0d required=%0d", i, level, lvl);
      end
    end
    act_ready = 1'b1;
    wait_drain(ok);
    checks++;
    if (!ok || overflow !== 1'b0 || level !== '0) begin
      failures++;
      $display("FAIL wrap_drain pending=%0d ovf=%b lvl=%0d required 0 0 0",
               expect_q.size(), overflow, level);
    end
  endtask

  task automatic test_flush();
    bit ok;
    act_ready = 1'b0;
    push_cmd(2'd3, rnd_pl(1'b1), 1'b1, 1'b0);
    push_cmd(2'd0, rnd_pl(1'b0), 1'b1, 1'b0);
    checks++;
    if (level !== 3'd2 || level_f !== 3'd2) begin
      failures++;
      $display("FAIL flush_prefill lvl=%0d lvl_f=%0d required 2 2", level, level_f);
    end
    vs_uir = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ir_update !== (k == SYNC + 1) || ir_update_f !== (k == SYNC + 1) ||
          (take_action_f | take_no_action_f) !== '0) begin
        failures++;
        $display("FAIL flush_ir_update k=%0d iru=%b iru_f=%b act_f=%b required iru=%b act_f=0",
                 k, ir_update, ir_update_f, take_action_f | take_no_action_f, k == SYNC + 1);
      end
    end
    vs_uir = 1'b0;
    checks++;
    if (level_f !== '0 || level !== 3'd2) begin
      failures++;
      $display("FAIL flush_level lvl_f=%0d lvl=%0d required 0 2", level_f, level);
    end
    act_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      checks++;
      if ((take_action_f | take_no_action_f) !== '0) begin
        failures++;
        $display("FAIL flush_no_dispatch k=%0d act_f=%b required=0", k,
                 take_action_f | take_no_action_f);
      end
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL noflush_drain pending=%0d required=0", expect_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    act_ready = 1'b0;
    push_cmd(2'd1, rnd_pl(1'b1), 1'b0, 1'b0);
    push_cmd(2'd2, rnd_pl(1'b0), 1'b0, 1'b0);
    push_cmd(2'd3, rnd_pl(1'b1), 1'b0, 1'b1);
    checks++;
    if (level !== 3'd3) begin failures++; $display("FAIL rst_prefill got=%0d required=3", level); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    checks++;
    if ({jdo, take_action, take_no_action, ir_update, overflow, level} !== '0) begin
      failures++;
      $display("FAIL rst_mid_state jdo=%h ta=%b tna=%b iru=%b ovf=%b lvl=%0d required all zero",
               jdo, take_action, take_no_action, ir_update, overflow, level);
    end
    act_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if ((take_action | take_no_action) !== '0 || level !== '0) begin
        failures++;
        $display("FAIL rst_held_udr k=%0d act=%b lvl=%0d required 0 0", k,
                 take_action | take_no_action, level);
      end
    end
    vs_udr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_cmd(2'd2, rnd_pl(1'b1), 1'b1, 1'b0);
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rst_fresh_drain pending=%0d required=0", expect_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_debug_slave_cmd_queue.md
# cpu_debug_slave_cmd_queue

Parametrised system-clock command stage for the CPU debug slave. It samples the update-IR and update-DR strobes coming from the JTAG shift logic and captures the shift-register payload and IR code. It queues the captured commands and replays each one as a one-cycle take-action or take-no-action pulse per IR channel, throttled by the debug core's ready. It generalises the fixed 2-bit-IR, 38-bit, unbuffered capture path: IR width, payload width and queue depth are parametrised, and the block adds backpressure, overflow reporting and optional flush-on-IR-update.

## Interface
- SR_W, 38: payload (shift register / jdo) width, ≥ 2
- IR_W, 2: IR code width; NUM_CH = 2**IR_W action channels
- DEPTH, 4: command queue entries, power of two, ≥ 2
- SYNC_STAGES, 2: synchroniser flops on vs_udr/vs_uir, ≥ 2
- FLUSH_ON_UIR, 0: 1 = rising vs_uir empties the queue

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; synchronous and active-low
- sr  in  SR_W  JTAG shift register, quasi-static around vs_udr
- ir_in  in  IR_W  JTAG IR code, quasi-static around vs_udr
- vs_udr  in  1  update-DR level from JTAG domain, asynchronous to clk
- vs_uir  in  1  update-IR level from JTAG domain, asynchronous to clk
- act_ready  in  1  debug core can accept a command this cycle
- ovf_clr  in  1  clears sticky overflow
- jdo  out  SR_W  payload of last dispatched command
- take_action  out  NUM_CH  one-cycle pulse, bit = dispatched IR code, when payload MSB = 1
- take_no_action  out  NUM_CH  same, when payload MSB = 0
- ir_update  out  1  one-cycle pulse per synchronised vs_uir rise
- overflow  out  1  sticky: a command was dropped
- level  out  $clog2(DEPTH)+1  current queue occupancy

## Operation
- vs_udr and vs_uir each pass through a SYNC_STAGES flop chain, then a rising-edge detector (one further register).
- udr_edge: push {ir_in, sr} into the FIFO. Sampling happens the same cycle the edge is detected.
- Dispatch: when the queue is non-empty and act_ready = 1, pop the head. Next cycle:
  - jdo = popped payload.
  - Exactly one bit of take_action or take_no_action is high, at index = popped IR, selected by payload[SR_W-1].
- Outside dispatch: pulse outputs are 0 and jdo holds its value.
- Full queue, push without pop: command dropped and overflow set. Full queue with push and pop in the same cycle: both happen and level is unchanged.
- Empty queue with push: no same-cycle bypass. The entry becomes poppable the next cycle.
- uir_edge: ir_update pulses. If FLUSH_ON_UIR = 1:
  - Read and write pointers reset and level goes to 0.
  - Flush wins over a same-cycle push and pop. Nothing is dispatched that cycle.
- Overflow and ovf_clr: ovf_clr clears overflow. If a drop occurs in the same cycle, set wins.
- Pointers: $clog2(DEPTH) bits plus a wrap bit. Full/empty are decoded from pointer equality and the wrap bit. Pointers wrap modulo DEPTH.

## Timing
- Reset (reset_n low at a clk edge): jdo = 0, take_action = 0, take_no_action = 0, ir_update = 0, overflow = 0, level = 0. Synchroniser and edge registers are cleared and the queue is emptied.
- Reset mid-stream discards all queued and in-flight commands. A vs_udr held high across reset release produces no edge.
- Latency, empty queue and act_ready = 1: the pulse is high SYNC_STAGES + 2 cycles after the first clk edge that samples vs_udr = 1.
- Latency of ir_update from the first sampled vs_uir = 1: SYNC_STAGES + 1 cycles.
- Throughput: one dispatch per cycle while act_ready = 1 and the queue is non-empty.
- The JTAG side holds sr/ir_in stable for ≥ SYNC_STAGES + 2 clk cycles after raising vs_udr; this block does no further checking.

## Structure
- Package cpu_debug_slave_pkg:
  - Default widths.
  - Command struct typedef {ir, payload}.
  - Function for the channel-onehot decode.
- Sub-module cpu_debug_slave_sync_edge (SYNC_STAGES parameter):
  - Synchroniser plus rising-edge register, synchronous active-low reset.
  - Instantiated twice (udr, uir).
- Queue storage is a plain register array in the top module; no RAM macro.

## Test plan
- Single command, SR_W = 38, IR_W = 2: ir_in = 2, sr[37] = 1, sr = 38'h20_0000_00AB, act_ready = 1, pulse vs_udr.
  - take_action = 4'b0100 for exactly 1 cycle at SYNC_STAGES + 2.
  - jdo = 38'h20_0000_00AB.
- Backpressure: act_ready = 0, push 3 commands (ir = 0, 1, 3; MSB = 0, 1, 0).
  - level goes 1, 2, 3.
  - After act_ready = 1: take_no_action[0], take_action[1], take_no_action[3] on consecutive cycles.
- Overflow, DEPTH = 4, act_ready = 0, 5 pushes:
  - level = 4, overflow = 1, 5th command absent on drain.
  - ovf_clr pulse: overflow = 0.
  - ovf_clr in the same cycle as a drop: overflow stays 1.
- Wrap-around: 10 push/pop pairs with DEPTH = 4 and act_ready toggling. Dispatched sequence equals the pushed sequence, and level never exceeds 4.
- Flush: FLUSH_ON_UIR = 1, 2 queued commands, pulse vs_uir.
  - ir_update pulses and level = 0, with no dispatch pulses.
  - Same test with FLUSH_ON_UIR = 0: both commands still dispatch.
- Reset mid-operation: 3 queued commands, reset_n low for 1 cycle with vs_udr held high.
  - All outputs 0 and level = 0.
  - No dispatch until a fresh vs_udr low→high.
